// File: rtl/fpdiv_ctrl_if.sv
// Handshake and control bundle between the FPU issue logic and the
// fpdiv sequencing controller. The issuer (master) drives start, rounding
// mode and the datapath op_type. The controller (slave) returns register
// enables, multiplier operand selects and completion status.
interface fpdiv_ctrl_if;
  logic       start;
  logic       rm_in;
  logic [1:0] op_type;
  logic       en_a;
  logic       en_b;
  logic       en_rem;
  logic [1:0] sel_mux3;
  logic [1:0] sel_mux4;
  logic       rm;
  logic       busy;
  logic       done;
  logic [1:0] op_type_q;

  modport master (
    output start, rm_in, op_type,
    input  en_a, en_b, en_rem, sel_mux3, sel_mux4, rm, busy, done, op_type_q
  );

  modport slave (
    input  start, rm_in, op_type,
    output en_a, en_b, en_rem, sel_mux3, sel_mux4, rm, busy, done, op_type_q
  );
endinterface

// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl: sequencing FSM for the Goldschmidt divider datapath.
// Walks N0, D0, ITERATIONS x (IA, IB), an optional REM step, then DONE.
// Optional feature macro: FPDIV_CTRL_REM_STEP_EN
//   defined   -> REM state present, en_rem pulses once per divide
//   undefined -> REM removed, en_rem tied 0, latency one cycle shorter
module fpdiv_ctrl #(
  parameter int ITERATIONS = 3
) (
  input  logic         clk,
  input  logic         reset,
  fpdiv_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_N0   = 3'd1,
    S_D0   = 3'd2,
    S_IA   = 3'd3,
    S_IB   = 3'd4,
    S_REM  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  // iter_cnt holds the number of completed IB cycles; the last IB is the
  // one that sees ITERATIONS-1 before incrementing.
  localparam logic [3:0] LAST_ITER = 4'(ITERATIONS - 1);

`ifdef FPDIV_CTRL_REM_STEP_EN
  localparam state_t AFTER_LAST_IB = S_REM;
`else
  localparam state_t AFTER_LAST_IB = S_DONE;
`endif

  state_t     state_reg, state_next;
  logic [3:0] iter_cnt_reg, iter_cnt_next;
  logic       rm_reg, rm_next;
  logic [1:0] op_type_q_reg, op_type_q_next;

  logic       en_a_next;
  logic       en_b_next;
  logic       en_rem_next;
  logic [1:0] sel_mux3_next;
  logic [1:0] sel_mux4_next;
  logic       busy_next;
  logic       done_next;

  // State, iteration counter and captured side-band values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      iter_cnt_reg  <= 4'd0;
      rm_reg        <= 1'b0;
      op_type_q_reg <= 2'd0;
    end else begin
      state_reg     <= state_next;
      iter_cnt_reg  <= iter_cnt_next;
      rm_reg        <= rm_next;
      op_type_q_reg <= op_type_q_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE so any pulse while
  // busy (including the DONE cycle) is simply dropped.
  always_comb begin
    state_next     = state_reg;
    iter_cnt_next  = iter_cnt_reg;
    rm_next        = rm_reg;
    op_type_q_next = op_type_q_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next    = S_N0;
          rm_next       = bus.rm_in;
          iter_cnt_next = 4'd0;
        end
      end
      S_N0: state_next = S_D0;
      S_D0: state_next = S_IA;
      // IA consumes regc before IB overwrites it, so IA always leads.
      S_IA: state_next = S_IB;
      S_IB: begin
        iter_cnt_next = iter_cnt_reg + 4'd1;
        if (iter_cnt_reg != LAST_ITER) begin
          state_next = S_IA;
        end else begin
          state_next = AFTER_LAST_IB;
        end
      end
`ifdef FPDIV_CTRL_REM_STEP_EN
      S_REM: state_next = S_DONE;
`endif
      S_DONE: begin
        state_next     = S_IDLE;
        op_type_q_next = bus.op_type;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    en_a_next     = 1'b0;
    en_b_next     = 1'b0;
    en_rem_next   = 1'b0;
    sel_mux3_next = 2'd0;
    sel_mux4_next = 2'd0;
    busy_next     = 1'b1;
    done_next     = 1'b0;
    case (state_reg)
      S_IDLE: busy_next = 1'b0;
      // rega <- initial approx * num
      S_N0: begin
        sel_mux3_next = 2'd0;
        sel_mux4_next = 2'd0;
        en_a_next     = 1'b1;
      end
      // regb, regc <- initial approx * denom
      S_D0: begin
        sel_mux3_next = 2'd0;
        sel_mux4_next = 2'd1;
        en_b_next     = 1'b1;
      end
      // rega <- regc * rega
      S_IA: begin
        sel_mux3_next = 2'd1;
        sel_mux4_next = 2'd2;
        en_a_next     = 1'b1;
      end
      // regb, regc <- regc * regb
      S_IB: begin
        sel_mux3_next = 2'd1;
        sel_mux4_next = 2'd3;
        en_b_next     = 1'b1;
      end
`ifdef FPDIV_CTRL_REM_STEP_EN
      // rem <- denom * rega, used by RN/RZ rounding
      S_REM: begin
        sel_mux3_next = 2'd2;
        sel_mux4_next = 2'd2;
        en_rem_next   = 1'b1;
      end
`endif
      S_DONE: done_next = 1'b1;
      default: busy_next = 1'b0;
    endcase
  end

  assign bus.en_a      = en_a_next;
  assign bus.en_b      = en_b_next;
  assign bus.en_rem    = en_rem_next;
  assign bus.sel_mux3  = sel_mux3_next;
  assign bus.sel_mux4  = sel_mux4_next;
  assign bus.busy      = busy_next;
  assign bus.done      = done_next;
  assign bus.rm        = rm_reg;
  assign bus.op_type_q = op_type_q_reg;

endmodule
